// File: rtl/vga_text_controller.sv
// VGA sync generator with an N-slot text overlay read from an external synchronous font ROM.
// Slot tables are double-buffered: writes land in a shadow copy that becomes active at frame start.
module vga_text_controller #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   N_SLOTS  = 8,
    parameter int   SLOT_W   = 3,
    parameter int   ADDR_W   = 11,
    parameter int   GLYPH_W  = 16,
    parameter int   GLYPH_H  = 16,
    parameter int   TEXT_X   = 64,
    parameter int   TEXT_Y   = 224
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  logic [ADDR_W-1:0]   addr_fixed,
    input  logic                wr_enable_slot,
    input  logic                wr_clr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [GLYPH_W-1:0]  rom_data,
    output logic                h_sync,
    output logic                v_sync,
    output logic                led_on,
    output logic                video_active,
    output logic                frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(CLK_DIV);
    localparam int CW       = $clog2(GLYPH_W);
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int TX_LAST  = TEXT_X + N_SLOTS * GLYPH_W - 1;
    localparam int TY_LAST  = TEXT_Y + GLYPH_H - 1;

    logic [DW-1:0]     r_div;
    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic              w_tick;
    logic              w_h_last;
    logic              w_v_last;

    logic              r_sh_en    [N_SLOTS];
    logic [ADDR_W-1:0] r_sh_base  [N_SLOTS];
    logic              r_act_en   [N_SLOTS];
    logic [ADDR_W-1:0] r_act_base [N_SLOTS];

    logic [HW-1:0]     w_dx;
    logic [SLOT_W-1:0] w_slot;
    logic [CW-1:0]     w_col;
    logic [VW-1:0]     w_row;
    logic              w_in_x;
    logic              w_in_y;
    logic              w_in_cell;
    logic [ADDR_W-1:0] w_cell_addr;
    logic              w_hs;
    logic              w_vs;
    logic              w_va;

    logic              r_s1_in_cell;
    logic [CW-1:0]     r_s1_col;
    logic              r_s1_va;
    logic              r_s1_hs;
    logic              r_s1_vs;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_led;
    logic              r_hs;
    logic              r_vs;
    logic              r_va;

    assign w_tick      = (r_div == DW'(CLK_DIV - 1));
    assign w_h_last    = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last    = (r_v_cnt == VW'(V_TOTAL - 1));
    assign frame_start = w_tick && (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + HW'(1);
                end
            end
        end
    end

    // Stage S0: decode the current counter position against the active slot table.
    always_comb begin
        w_dx        = r_h_cnt - HW'(TEXT_X);
        w_slot      = SLOT_W'(w_dx / HW'(GLYPH_W));
        w_col       = CW'(w_dx % HW'(GLYPH_W));
        w_row       = r_v_cnt - VW'(TEXT_Y);
        w_in_x      = (int'(r_h_cnt) >= TEXT_X) && (int'(r_h_cnt) <= TX_LAST);
        w_in_y      = (int'(r_v_cnt) >= TEXT_Y) && (int'(r_v_cnt) <= TY_LAST);
        w_in_cell   = w_in_x && w_in_y && r_act_en[w_slot];
        w_cell_addr = r_act_base[w_slot] + ADDR_W'(w_row);
        w_hs        = ((int'(r_h_cnt) >= HS_FIRST) && (int'(r_h_cnt) <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        w_vs        = ((int'(r_v_cnt) >= VS_FIRST) && (int'(r_v_cnt) <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        w_va        = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    end

    // S1 issues the ROM read; S2 picks the glyph bit once rom_data has settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_in_cell <= 1'b0;
            r_s1_col     <= '0;
            r_s1_va      <= 1'b0;
            r_s1_hs      <= ~SYNC_POL;
            r_s1_vs      <= ~SYNC_POL;
            r_rom_addr   <= '0;
            r_led        <= 1'b0;
            r_hs         <= ~SYNC_POL;
            r_vs         <= ~SYNC_POL;
            r_va         <= 1'b0;
        end else if (w_tick) begin
            r_s1_in_cell <= w_in_cell;
            r_s1_col     <= w_col;
            r_s1_va      <= w_va;
            r_s1_hs      <= w_hs;
            r_s1_vs      <= w_vs;
            if (w_in_cell) begin
                r_rom_addr <= w_cell_addr;
            end
            r_led <= r_s1_in_cell && r_s1_va && rom_data[CW'(GLYPH_W - 1) - r_s1_col];
            r_hs  <= r_s1_hs;
            r_vs  <= r_s1_vs;
            r_va  <= r_s1_va;
        end
    end

    // Later nonblocking writes win, so a write in the same clk as wr_clr keeps its enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                r_sh_en[i]    <= 1'b0;
                r_sh_base[i]  <= '0;
                r_act_en[i]   <= 1'b0;
                r_act_base[i] <= '0;
            end
        end else begin
            if (wr_clr) begin
                for (int unsigned i = 0; i < N_SLOTS; i++) begin
                    r_sh_en[i] <= 1'b0;
                end
            end
            if (wr_en) begin
                r_sh_en[wr_slot]   <= wr_enable_slot;
                r_sh_base[wr_slot] <= addr_fixed;
            end
            if (frame_start) begin
                for (int unsigned i = 0; i < N_SLOTS; i++) begin
                    r_act_en[i]   <= r_sh_en[i];
                    r_act_base[i] <= r_sh_base[i];
                end
            end
        end
    end

    assign rom_addr     = r_rom_addr;
    assign led_on       = r_led;
    assign h_sync       = r_hs;
    assign v_sync       = r_vs;
    assign video_active = r_va;

endmodule

// File: doc/vga_text_controller.md
Name: vga_text_controller

Overview:
- Parametrised VGA timing and text-overlay engine that generalises the single-position Morse character display to N character slots.
- Generates h_sync/v_sync from a divided pixel tick and reads glyph rows from an external synchronous font ROM.
- Drives led_on for each pixel inside an enabled slot.
- Slot contents are double-buffered and swap at frame start, so updates from the Morse decoder never tear mid-frame.

Parameters:
- CLK_DIV, 4, clk cycles per pixel tick (>=2)
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- SYNC_POL, 0, sync asserted level (0 = active low)
- N_SLOTS, 8, number of character slots
- SLOT_W, 3, slot index width (clog2 N_SLOTS)
- ADDR_W, 11, font ROM address width
- GLYPH_W, 16, glyph width in pixels; also the ROM data width
- GLYPH_H, 16, glyph height in rows
- TEXT_X, 64, x of slot 0 left edge
- TEXT_Y, 224, y of glyph row 0

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one slot's shadow entry
- wr_slot  in  SLOT_W  slot index for the write
- addr_fixed  in  ADDR_W  glyph base ROM address for the write
- wr_enable_slot  in  1  written slot-enable bit
- wr_clr  in  1  clear all shadow enables
- rom_addr  out  ADDR_W  font ROM read address
- rom_data  in  GLYPH_W  ROM row data, valid 1 clk after rom_addr
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- led_on  out  1  pixel lit
- video_active  out  1  pixel within the visible area
- frame_start  out  1  one-clk pulse at pixel (0,0)

Behaviour:
- Reset: all counters 0; h_sync=v_sync=~SYNC_POL; led_on=0; video_active=0; frame_start=0; rom_addr=0; shadow and active slot tables cleared (enable=0, base=0). Reset mid-frame restarts at pixel (0,0) on the next cycle.
- Divider: counts 0..CLK_DIV-1; pixel_tick is asserted when the count equals CLK_DIV-1.
- h_cnt: advances on pixel_tick, wraps at H_TOTAL-1 to 0 (H_TOTAL = sum of the H params).
- v_cnt: advances when h_cnt wraps, wraps at V_TOTAL-1.
- Sync: h_sync asserted (=SYNC_POL) while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. v_sync is defined the same way on v_cnt.
- Pipeline stage S0 (counters) -> S1 (registered on pixel_tick):
  - slot = (h_cnt-TEXT_X)/GLYPH_W
  - col = (h_cnt-TEXT_X)%GLYPH_W
  - row = v_cnt-TEXT_Y
  - in_cell = h_cnt in [TEXT_X, TEXT_X+N_SLOTS*GLYPH_W-1] and v_cnt in [TEXT_Y, TEXT_Y+GLYPH_H-1] and active enable[slot]
  - rom_addr = active base[slot] + row, truncated to ADDR_W (wrap, no saturation)
- Stage S2 (next pixel_tick): led_on = in_cell_d & video_active_d & rom_data[GLYPH_W-1-col_d].
- Alignment: h_sync, v_sync and video_active are delayed 2 pixel ticks, so all outputs align with led_on. Total latency from counter to output is 2 pixel ticks.
- When out of a cell, rom_addr holds its previous value and led_on=0.
- Shadow write (any clk): wr_en writes base and enable for wr_slot. wr_clr clears all shadow enables. If both are asserted, wr_clr is applied first and then the write, so the written slot keeps wr_enable_slot.
- Swap: on the clk where frame_start=1, active <= shadow. A write in that same clk lands in shadow only and becomes visible the following frame.
- frame_start: one clk pulse when S0 h_cnt=0, v_cnt=0 and pixel_tick=1.

Test Plan:
- Default params, run 2 frames -> h_sync low for 96 pixel ticks (384 clk) out of every 800 (3200 clk). v_sync low for 2 lines out of 525. frame_start period = 1,680,000 clk.
- Write slot 0, addr_fixed=100, enable=1, mid-frame -> no led_on this frame. Next frame, at v_cnt=TEXT_Y+3, rom_addr=103 while S1 x is in [64,79].
- ROM model returns 16'h8001 -> led_on=1 only at output x=64 and x=79 of slot 0, 2 pixel ticks after those counter values.
- Write slot 7, addr=2047, enable=1 -> row 1 gives rom_addr=0 (wrap). wr_clr then takes effect at the next frame start: all led_on=0.
- wr_en coincident with the frame_start clk -> active table unchanged for that frame; update visible one frame later.
- Assert reset at v_cnt=300 -> next clk: outputs at reset values, counters 0, tables cleared. Timing resumes identically from (0,0).
